mdu_unit: RTL and testbench

- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Holds the HI/LO architectural registers and executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency.
- Executes MTHI/MTLO/MFHI/MFLO.
- Drives `start` and `busy` directly into the D-stage stall controller, which stalls any D-stage md instruction while `start | busy`.

---
 rtl/mdu_unit_if.sv | 22 ++
 rtl/mdu_unit.sv | 120 ++++++++++++
 tb/tb_mdu_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_unit_if.sv
// Operand/result bundle between the E stage and the multiply/divide unit.
// master = pipeline side, slave = mdu_unit.
interface mdu_unit_if;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  modport master (
    output md_op, rs_val, rt_val,
    input  start, busy, hi, lo, md_out
  );

  modport slave (
    input  md_op, rs_val, rt_val,
    output start, busy, hi, lo, md_out
  );
endinterface

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs MULT/DIV over a fixed latency
// and commits the precomputed 64-bit result when the countdown expires.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_unit_if.slave md
);
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [63:0]   r_pend;

  logic               w_busy;
  logic               w_is_md;
  logic               w_start;
  logic               w_is_mult;
  logic               w_div0;
  logic               w_sdiv_ovf;
  logic [31:0]        w_udivisor;
  logic signed [31:0] w_sdivisor;
  logic signed [31:0] w_squot;
  logic signed [31:0] w_srem;
  logic signed [63:0] w_sprod;
  logic [63:0]        w_uprod;
  logic [63:0]        w_result;
  logic [31:0]        w_md_out;

  assign w_busy    = (r_state == ST_RUN);
  assign w_is_md   = (md.md_op >= OP_MULT) && (md.md_op <= OP_DIVU);
  assign w_start   = w_is_md && !w_busy;
  assign w_is_mult = (md.md_op == OP_MULT) || (md.md_op == OP_MULTU);

  // Divisors are steered away from 0 and from the INT_MIN/-1 overflow so the
  // dividers never see an undefined case; MIN/1 yields the required MIN, rem 0.
  assign w_div0     = (md.rt_val == 32'd0);
  assign w_sdiv_ovf = (md.rs_val == 32'h8000_0000) && (md.rt_val == 32'hFFFF_FFFF);
  assign w_udivisor = w_div0 ? 32'd1 : md.rt_val;
  assign w_sdivisor = (w_div0 || w_sdiv_ovf) ? 32'sd1 : $signed(md.rt_val);

  assign w_squot = $signed(md.rs_val) / w_sdivisor;
  assign w_srem  = $signed(md.rs_val) % w_sdivisor;
  assign w_sprod = $signed({{32{md.rs_val[31]}}, md.rs_val}) *
                   $signed({{32{md.rt_val[31]}}, md.rt_val});
  assign w_uprod = {32'd0, md.rs_val} * {32'd0, md.rt_val};

  always_comb begin
    w_result = {r_hi, r_lo};
    case (md.md_op)
      OP_MULT:  w_result = w_sprod;
      OP_MULTU: w_result = w_uprod;
      OP_DIV:   if (!w_div0) w_result = {w_srem, w_squot};
      OP_DIVU:  if (!w_div0) w_result = {md.rs_val % w_udivisor, md.rs_val / w_udivisor};
      default:  w_result = {r_hi, r_lo};
    endcase
  end

  always_comb begin
    w_md_out = 32'd0;
    if (md.md_op == OP_MFHI)      w_md_out = r_hi;
    else if (md.md_op == OP_MFLO) w_md_out = r_lo;
  end

  // Divide-by-zero pends the current HI/LO, which nothing can alter while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_pend  <= 64'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_pend  <= w_result;
            r_cnt   <= w_is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            r_state <= ST_RUN;
          end else if (md.md_op == OP_MTHI) begin
            r_hi <= md.rs_val;
          end else if (md.md_op == OP_MTLO) begin
            r_lo <= md.rs_val;
          end
        end
        default: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_hi    <= r_pend[63:32];
            r_lo    <= r_pend[31:0];
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign md.start  = w_start;
  assign md.busy   = w_busy;
  assign md.hi     = r_hi;
  assign md.lo     = r_lo;
  assign md.md_out = w_md_out;
endmodule

// File: tb/tb_mdu_unit.sv
// Randomized scoreboard bench for mdu_unit: stimulus pushes model results,
// a negedge monitor pops them on every commit and every MFHI/MFLO read.
module tb_mdu_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk;
  logic reset;
  mdu_unit_if bus ();

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) u_dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  int checks = 0;
  int errors = 0;
  exp_t        sb_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%08h expected=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on the architectural rules.
  function automatic void model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd3: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        p = 64'(q); m_lo = p[31:0];
        p = 64'(r); m_hi = p[31:0];
      end
      4'd4: if (b != 0) begin
        uq = {32'd0, a} / {32'd0, b}; ur = {32'd0, a} % {32'd0, b};
        m_lo = uq[31:0]; m_hi = ur[31:0];
      end
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit junk);
    int n;
    n = (op <= 4'd2) ? MC : DC;
    bus.md_op = op; bus.rs_val = a; bus.rt_val = b;
    #1;
    chk("start_issue", {31'd0, bus.start}, 32'd1);
    model_exec(op, a, b);
    sb_q.push_back('{hi: m_hi, lo: m_lo});
    $display("issue op=%0d rs=%08h rt=%08h -> hi=%08h lo=%08h", op, a, b, m_hi, m_lo);
    tick();
    bus.md_op = 4'd0;
    for (int k = 1; k <= n; k++) begin
      chk("busy_run", {31'd0, bus.busy}, 32'd1);
      if (junk && k <= 2) begin
        bus.md_op = (k == 1) ? 4'd1 : 4'd5;
        bus.rs_val = $urandom; bus.rt_val = $urandom;
        #1;
        chk("start_ignored", {31'd0, bus.start}, 32'd0);
      end
      tick();
      bus.md_op = 4'd0;
    end
    chk("busy_done", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    bus.md_op = op; bus.rs_val = v; bus.rt_val = $urandom;
    #1;
    chk("start_mt", {31'd0, bus.start}, 32'd0);
    tick();
    bus.md_op = 4'd0;
    if (op == 4'd5) m_hi = v; else m_lo = v;
    $display("mt op=%0d val=%08h", op, v);
    chk("mt_hi", bus.hi, m_hi);
    chk("mt_lo", bus.lo, m_lo);
  endtask

  task automatic mf(input logic [3:0] op);
    bus.md_op = op;
    rd_q.push_back((op == 4'd7) ? m_hi : m_lo);
    $display("mf op=%0d expect=%08h", op, (op == 4'd7) ? m_hi : m_lo);
    tick();
    bus.md_op = 4'd0;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: commit = busy falling without reset on that edge.
  logic prev_busy = 1'b0;
  logic prev_reset = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] r;
    if (prev_busy === 1'b1 && bus.busy === 1'b0) begin
      if (prev_reset) begin
        chk("reset_abort_hi", bus.hi, 32'd0);
        chk("reset_abort_lo", bus.lo, 32'd0);
      end else if (sb_q.size() == 0) begin
        chk("unexpected_commit", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("commit_hi", bus.hi, e.hi);
        chk("commit_lo", bus.lo, e.lo);
      end
    end
    if (bus.md_op == 4'd7 || bus.md_op == 4'd8) begin
      if (rd_q.size() == 0) chk("unexpected_mf", 32'd1, 32'd0);
      else begin
        r = rd_q.pop_front();
        chk("md_out", bus.md_out, r);
      end
    end else if (!reset) begin
      chk("md_out_idle", bus.md_out, 32'd0);
    end
    prev_busy  <= bus.busy;
    prev_reset <= reset;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] op;
    reset = 1'b1;
    bus.md_op = 4'd0; bus.rs_val = 32'd0; bus.rt_val = 32'd0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    mf(4'd8);

    run_md(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFFA);
    run_md(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("multu_hi", bus.hi, 32'h0000_0001);
    chk("multu_lo", bus.lo, 32'hFFFF_FFFE);
    run_md(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    run_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("divovf_hi", bus.hi, 32'd0);
    chk("divovf_lo", bus.lo, 32'h8000_0000);
    mt(4'd5, 32'h11);
    mt(4'd6, 32'h22);
    run_md(4'd4, 32'h1234_5678, 32'd0, 1'b0);
    chk("div0_hi", bus.hi, 32'h11);
    chk("div0_lo", bus.lo, 32'h22);
    run_md(4'd1, 32'd7, 32'hFFFF_FFFD, 1'b1);
    chk("ignored_hi", bus.hi, 32'hFFFF_FFFF);
    chk("ignored_lo", bus.lo, 32'hFFFF_FFEB);
    mf(4'd7);
    mf(4'd8);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 8));
      if (op <= 4'd4)      run_md(op, rnd_val(), rnd_val(), 1'($urandom_range(0, 1)));
      else if (op <= 4'd6) mt(op, rnd_val());
      else                 mf(op);
    end

    // Reset during the 4th busy cycle of a DIV discards the result.
    mt(4'd5, 32'hAAAA_5555);
    bus.md_op = 4'd3; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    tick();
    bus.md_op = 4'd0;
    tick(); tick(); tick();
    chk("busy_before_rst", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    $display("reset during DIV busy");
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mid_hi", bus.hi, 32'd0);
    chk("rst_mid_lo", bus.lo, 32'd0);
    for (int k = 0; k < DC + 2; k++) begin
      tick();
      chk("no_late_busy", {31'd0, bus.busy}, 32'd0);
      chk("no_late_commit", bus.lo, 32'd0);
    end
    run_md(4'd4, 32'd100, 32'd7, 1'b0);
    chk("post_rst_lo", bus.lo, 32'd14);
    chk("post_rst_hi", bus.hi, 32'd2);

    tick(); tick();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("rd_drained", 32'(rd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
